ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 120 ++++++++++++
 tb/tb_ifu_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit with a single-outstanding memory request,
// a one-entry instruction buffer toward decode, and branch/JAL/JALR redirect
// handling with a kill flag that drops the response of a superseded fetch.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic        i_redirect_jalr,
  input  logic [31:0] i_base,
  input  logic [31:0] i_imm,
  output logic [31:0] o_ins,
  output logic [31:0] o_pc,
  output logic        o_ins_vld,
  input  logic        i_ins_rdy,
  output logic        o_misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  fetch_state_e state;
  logic [31:0]  pc_f;
  logic [31:0]  addr_q;
  logic         kill;

  logic [31:0]  target_sum;
  logic [31:0]  target;
  logic         redir_ok;
  logic         redir_bad;
  logic         consume;

  // JALR clears bit 0 of the sum; a target with bit 1 set is not word aligned
  // and is refused instead of being followed.
  assign target_sum = i_base + i_imm;
  assign target     = {target_sum[31:1], target_sum[0] & ~i_redirect_jalr};
  assign redir_ok   = i_redirect & ~target[1];
  assign redir_bad  = i_redirect &  target[1];
  assign consume    = o_ins_vld & i_ins_rdy;

  // Fetch FSM, fetch PC, instruction buffer and kill tracking; an accepted
  // redirect is applied last so it overrides increment, capture and consume.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      pc_f        <= RESET_PC;
      addr_q      <= 32'h0;
      kill        <= 1'b0;
      o_imem_req  <= 1'b0;
      o_imem_addr <= 32'h0;
      o_ins       <= 32'h0;
      o_pc        <= 32'h0;
      o_ins_vld   <= 1'b0;
      o_misalign  <= 1'b0;
    end else begin
      o_misalign <= redir_bad;

      if (consume) begin
        o_ins_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Hold off while a redirect lands so the request uses the new PC.
          if (!redir_ok && (!o_ins_vld || i_ins_rdy)) begin
            state       <= REQ;
            o_imem_req  <= 1'b1;
            o_imem_addr <= pc_f;
          end
        end
        REQ: begin
          if (i_imem_gnt) begin
            state      <= WAIT;
            o_imem_req <= 1'b0;
            addr_q     <= o_imem_addr;
            if (!kill && !redir_ok) begin
              pc_f <= pc_f + 32'd4;
            end
          end
        end
        WAIT: begin
          if (i_imem_rvalid) begin
            state <= IDLE;
            if (kill || redir_ok) begin
              kill <= 1'b0;
            end else begin
              o_ins     <= i_imem_rdata;
              o_pc      <= addr_q;
              o_ins_vld <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          o_imem_req <= 1'b0;
        end
      endcase

      if (redir_ok) begin
        pc_f      <= target;
        o_ins_vld <= 1'b0;
        // The response arriving this very cycle is dropped above, so kill only
        // needs to remain armed when that response is still to come.
        if ((state == REQ) || (state == WAIT && !i_imem_rvalid)) begin
          kill <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed-vector bench for ifu_fetch with hand-computed
// expected values for fetch, stall, redirect, misalign, wrap and reset cases.
module tb_ifu_fetch;

  logic        i_clk;
  logic        i_reset;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic        i_redirect_jalr;
  logic [31:0] i_base;
  logic [31:0] i_imm;
  logic [31:0] o_ins;
  logic [31:0] o_pc;
  logic        o_ins_vld;
  logic        i_ins_rdy;
  logic        o_misalign;

  int num_compared;
  int num_mismatched;

  ifu_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_gnt     (i_imem_gnt),
    .i_imem_rvalid  (i_imem_rvalid),
    .i_imem_rdata   (i_imem_rdata),
    .i_redirect     (i_redirect),
    .i_redirect_jalr(i_redirect_jalr),
    .i_base         (i_base),
    .i_imm          (i_imm),
    .o_ins          (o_ins),
    .o_pc           (o_pc),
    .o_ins_vld      (o_ins_vld),
    .i_ins_rdy      (i_ins_rdy),
    .o_misalign     (o_misalign)
  );

  // Free-running 10 ns clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic gnt, input logic rvalid,
                               input logic [31:0] rdata, input logic rdy);
    i_imem_gnt    = gnt;
    i_imem_rvalid = rvalid;
    i_imem_rdata  = rdata;
    i_ins_rdy     = rdy;
  endtask

  task automatic applyRedirect(input logic redir, input logic jalr,
                               input logic [31:0] base, input logic [31:0] imm);
    i_redirect      = redir;
    i_redirect_jalr = jalr;
    i_base          = base;
    i_imm           = imm;
  endtask

  // Advance to 1 ns past the next rising edge; outputs are then stable.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    i_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyRedirect(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("rst_req",      32'(o_imem_req), 32'h0);
    checkOutput("rst_addr",     o_imem_addr,     32'h0);
    checkOutput("rst_vld",      32'(o_ins_vld),  32'h0);
    checkOutput("rst_ins",      o_ins,           32'h0);
    checkOutput("rst_pc",       o_pc,            32'h0);
    checkOutput("rst_misalign", 32'(o_misalign), 32'h0);

    // Basic fetch at minimum latency, then the sequential next request.
    i_reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("first_req",  32'(o_imem_req), 32'h1);
    checkOutput("first_addr", o_imem_addr,     32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("wait_req", 32'(o_imem_req), 32'h0);
    checkOutput("wait_vld", 32'(o_ins_vld),  32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0050_0093, 1'b1);
    tick();
    checkOutput("basic_vld", 32'(o_ins_vld), 32'h1);
    checkOutput("basic_ins", o_ins,          32'h0050_0093);
    checkOutput("basic_pc",  o_pc,           32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("next_req",  32'(o_imem_req), 32'h1);
    checkOutput("next_addr", o_imem_addr,     32'h4);
    checkOutput("next_vld",  32'(o_ins_vld),  32'h0);

    // Decode stall: buffer held and no new request while not ready.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'hAAAA_0013, 1'b0);
    tick();
    checkOutput("stall_ins", o_ins, 32'hAAAA_0013);
    checkOutput("stall_pc",  o_pc,  32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("stall_req",      32'(o_imem_req), 32'h0);
      checkOutput("stall_vld_hold", 32'(o_ins_vld),  32'h1);
      checkOutput("stall_ins_hold", o_ins,           32'hAAAA_0013);
      checkOutput("stall_pc_hold",  o_pc,            32'h4);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("resume_req",  32'(o_imem_req), 32'h1);
    checkOutput("resume_addr", o_imem_addr,     32'h8);
    checkOutput("resume_vld",  32'(o_ins_vld),  32'h0);

    // Redirect during WAIT: 0x100 + (-8) = 0xF8, in-flight response dropped.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyRedirect(1'b1, 1'b0, 32'h0000_0100, 32'hFFFF_FFF8);
    tick();
    applyRedirect(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_DEAD, 1'b1);
    tick();
    checkOutput("kill_wait_vld", 32'(o_ins_vld), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("redir_addr", o_imem_addr,    32'h0000_00F8);
    checkOutput("redir_req",  32'(o_imem_req), 32'h1);
    checkOutput("redir_vld",  32'(o_ins_vld), 32'h0);

    // Grant withheld five cycles; redirect to 0x310 inside the window.
    for (int k = 0; k < 5; k++) begin
      if (k == 2) applyRedirect(1'b1, 1'b0, 32'h0000_0300, 32'h0000_0010);
      else        applyRedirect(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      checkOutput("hold_req",  32'(o_imem_req), 32'h1);
      checkOutput("hold_addr", o_imem_addr,     32'h0000_00F8);
    end
    applyRedirect(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("hold_gnt_req", 32'(o_imem_req), 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hBEEF_BEEF, 1'b1);
    tick();
    checkOutput("hold_drop_vld", 32'(o_ins_vld), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("hold_new_addr", o_imem_addr, 32'h0000_0310);

    // Complete the fetch at 0x310 and leave it stalled in the buffer.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h1111_1111, 1'b0);
    tick();
    checkOutput("f310_vld", 32'(o_ins_vld), 32'h1);
    checkOutput("f310_pc",  o_pc,           32'h0000_0310);

    // Misaligned JALR 0x200 + 2 = 0x202: refused, pulse, buffer untouched.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyRedirect(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0002);
    tick();
    checkOutput("mis_pulse", 32'(o_misalign), 32'h1);
    checkOutput("mis_vld",   32'(o_ins_vld),  32'h1);
    checkOutput("mis_pc",    o_pc,            32'h0000_0310);
    applyRedirect(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("mis_clear",  32'(o_misalign), 32'h0);
    checkOutput("mis_pc_f",   o_imem_addr,     32'h0000_0314);

    // JALR 0x201 + 3 = 0x204 landing on the grant cycle: response dropped.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyRedirect(1'b1, 1'b1, 32'h0000_0201, 32'h0000_0003);
    tick();
    applyRedirect(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h5555_5555, 1'b1);
    tick();
    checkOutput("jalr_drop_vld", 32'(o_ins_vld), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("jalr_addr", o_imem_addr, 32'h0000_0204);

    // JALR 0xFFFFFFF0 + 0xD = 0xFFFFFFFD, bit 0 cleared -> 0xFFFFFFFC.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyRedirect(1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0000_000D);
    tick();
    checkOutput("bit0_misalign", 32'(o_misalign), 32'h0);
    applyRedirect(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h6666_6666, 1'b1);
    tick();
    checkOutput("bit0_drop_vld", 32'(o_ins_vld), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("top_addr", o_imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h2222_2222, 1'b1);
    tick();
    checkOutput("top_ins", o_ins, 32'h2222_2222);
    checkOutput("top_pc",  o_pc,  32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("wrap_addr", o_imem_addr, 32'h0);

    // Reset while in WAIT, late rvalid must not load the buffer.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    i_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("mid_rst_req", 32'(o_imem_req), 32'h0);
    checkOutput("mid_rst_pc",  o_pc,            32'h0);
    i_reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h7777_7777, 1'b1);
    tick();
    checkOutput("late_rv_vld",  32'(o_ins_vld),  32'h0);
    checkOutput("late_rv_req",  32'(o_imem_req), 32'h1);
    checkOutput("late_rv_addr", o_imem_addr,     32'h0);
    tick();
    checkOutput("late_rv_vld2", 32'(o_ins_vld),  32'h0);
    checkOutput("late_rv_req2", 32'(o_imem_req), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h3333_3333, 1'b1);
    tick();
    checkOutput("restart_ins", o_ins,          32'h3333_3333);
    checkOutput("restart_pc",  o_pc,           32'h0);
    checkOutput("restart_vld", 32'(o_ins_vld), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             num_compared, num_mismatched);
    $finish;
  end

endmodule
